// File: rtl/ssd1306_spi_receiver.sv
// SSD1306-style SPI display responder: oversampled SPI front end, command/data
// parser with parameter handling, and framebuffer write port with windowed addressing.
module ssd1306_spi_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_ss,
  input  logic       spi_dc,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_data,
  output logic       fb_we,
  output logic       frame_done,
  output logic       disp_on,
  output logic       invert,
  output logic [7:0] contrast,
  output logic [1:0] addr_mode
);

  typedef enum logic [1:0] {ST_IDLE, ST_PARAM, ST_SKIP} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync, dc_sync;
  logic                   sck_s, mosi_s, ss_s, dc_s, sck_prev, sck_rise;
  logic [6:0]             shift_reg;
  logic [2:0]             bit_cnt;
  logic                   byte_vld, rx_dc;
  logic [7:0]             rx_byte;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      dc_sync   <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
      sck_prev  <= sck_s;
    end
  end

  // byte_vld is a one-cycle valid with no ready: the parser accepts every byte
  // in the cycle it is offered, which bytes spaced at f_clk/4 always allow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      byte_vld  <= 1'b0;
      rx_byte   <= '0;
      rx_dc     <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      if (ss_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift_reg <= {shift_reg[5:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          rx_byte  <= {shift_reg, mosi_s};
          rx_dc    <= dc_s;
        end
      end
    end
  end

  state_t     state, state_nxt;
  logic [2:0] param_cnt, param_cnt_nxt;
  logic [7:0] opcode, opcode_nxt;
  logic [6:0] col, col_nxt, col_start, col_start_nxt, col_end, col_end_nxt;
  logic [2:0] page, page_nxt, page_start, page_start_nxt, page_end, page_end_nxt;
  logic       disp_on_nxt, invert_nxt, fb_we_nxt, frame_done_nxt;
  logic [7:0] contrast_nxt, fb_data_nxt;
  logic [1:0] addr_mode_nxt;
  logic [9:0] fb_addr_nxt;
  logic [6:0] adv_col;
  logic [2:0] adv_page;
  logic       adv_wrap;

  // Pointer position after the current one is written; a window whose start is
  // past its end simply runs through the modulo wrap until it hits the end.
  always_comb begin
    adv_col  = col;
    adv_page = page;
    adv_wrap = 1'b0;
    case (addr_mode)
      2'd0: begin
        if (col == col_end) begin
          adv_col = col_start;
          if (page == page_end) begin
            adv_page = page_start;
            adv_wrap = 1'b1;
          end else begin
            adv_page = page + 3'd1;
          end
        end else begin
          adv_col = col + 7'd1;
        end
      end
      2'd1: begin
        if (page == page_end) begin
          adv_page = page_start;
          if (col == col_end) begin
            adv_col  = col_start;
            adv_wrap = 1'b1;
          end else begin
            adv_col = col + 7'd1;
          end
        end else begin
          adv_page = page + 3'd1;
        end
      end
      default: adv_col = col + 7'd1;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    param_cnt_nxt  = param_cnt;
    opcode_nxt     = opcode;
    col_nxt        = col;
    page_nxt       = page;
    col_start_nxt  = col_start;
    col_end_nxt    = col_end;
    page_start_nxt = page_start;
    page_end_nxt   = page_end;
    disp_on_nxt    = disp_on;
    invert_nxt     = invert;
    contrast_nxt   = contrast;
    addr_mode_nxt  = addr_mode;
    fb_we_nxt      = 1'b0;
    frame_done_nxt = 1'b0;
    fb_addr_nxt    = fb_addr;
    fb_data_nxt    = fb_data;
    if (fb_we) begin
      col_nxt  = adv_col;
      page_nxt = adv_page;
    end
    if (byte_vld) begin
      case (state)
        ST_IDLE: begin
          if (rx_dc) begin
            fb_we_nxt      = 1'b1;
            fb_addr_nxt    = {page, col};
            fb_data_nxt    = rx_byte;
            frame_done_nxt = adv_wrap;
          end else begin
            opcode_nxt = rx_byte;
            casez (rx_byte)
              8'hAE: disp_on_nxt = 1'b0;
              8'hAF: disp_on_nxt = 1'b1;
              8'hA6: invert_nxt  = 1'b0;
              8'hA7: invert_nxt  = 1'b1;
              8'h81, 8'h20: begin
                state_nxt     = ST_PARAM;
                param_cnt_nxt = 3'd1;
              end
              8'h21, 8'h22: begin
                state_nxt     = ST_PARAM;
                param_cnt_nxt = 3'd2;
              end
              8'b1011_0???: page_nxt = rx_byte[2:0];
              8'b0000_????: col_nxt[3:0] = rx_byte[3:0];
              8'b0001_0???: col_nxt[6:4] = rx_byte[2:0];
              8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                state_nxt     = ST_SKIP;
                param_cnt_nxt = 3'd1;
              end
              8'hA3: begin
                state_nxt     = ST_SKIP;
                param_cnt_nxt = 3'd2;
              end
              8'h29, 8'h2A: begin
                state_nxt     = ST_SKIP;
                param_cnt_nxt = 3'd5;
              end
              8'h26, 8'h27: begin
                state_nxt     = ST_SKIP;
                param_cnt_nxt = 3'd6;
              end
              default: ;
            endcase
          end
        end
        ST_PARAM: begin
          param_cnt_nxt = param_cnt - 3'd1;
          if (param_cnt == 3'd1) state_nxt = ST_IDLE;
          case (opcode)
            8'h81: contrast_nxt = rx_byte;
            8'h20: addr_mode_nxt = (rx_byte[1:0] == 2'd3) ? 2'd2 : rx_byte[1:0];
            8'h21: begin
              if (param_cnt == 3'd2) begin
                col_start_nxt = rx_byte[6:0];
                col_nxt       = rx_byte[6:0];
              end else begin
                col_end_nxt = rx_byte[6:0];
              end
            end
            8'h22: begin
              if (param_cnt == 3'd2) begin
                page_start_nxt = rx_byte[2:0];
                page_nxt       = rx_byte[2:0];
              end else begin
                page_end_nxt = rx_byte[2:0];
              end
            end
            default: ;
          endcase
        end
        default: begin
          param_cnt_nxt = param_cnt - 3'd1;
          if (param_cnt == 3'd1) state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      param_cnt  <= '0;
      opcode     <= '0;
      col        <= '0;
      page       <= '0;
      col_start  <= 7'd0;
      col_end    <= 7'd127;
      page_start <= 3'd0;
      page_end   <= 3'd7;
      disp_on    <= 1'b0;
      invert     <= 1'b0;
      contrast   <= 8'h7F;
      addr_mode  <= 2'd2;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
    end else begin
      state      <= state_nxt;
      param_cnt  <= param_cnt_nxt;
      opcode     <= opcode_nxt;
      col        <= col_nxt;
      page       <= page_nxt;
      col_start  <= col_start_nxt;
      col_end    <= col_end_nxt;
      page_start <= page_start_nxt;
      page_end   <= page_end_nxt;
      disp_on    <= disp_on_nxt;
      invert     <= invert_nxt;
      contrast   <= contrast_nxt;
      addr_mode  <= addr_mode_nxt;
      fb_we      <= fb_we_nxt;
      frame_done <= frame_done_nxt;
      fb_addr    <= fb_addr_nxt;
      fb_data    <= fb_data_nxt;
    end
  end

endmodule
